// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the RV32I multicycle control unit: states, opcodes,
// ALUOp codes and datapath mux selects.
package multicycle_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Instruction fields in, datapath controls and status out, between the
// control unit (master) and the datapath (slave).
interface multicycle_control_fsm_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic             zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             AdrSrc;
  logic             MemWrite;
  logic             IRWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ImmSrc;
  logic             RegWrite;
  logic [2:0]       ALUControl;
  logic             illegal_instr;
  logic [CNT_W-1:0] instret;
  logic [3:0]       state_dbg;

  modport master (
    input  op, funct3, funct7_5, zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, illegal_instr, instret, state_dbg
  );

  modport slave (
    output op, funct3, funct7_5, zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, illegal_instr, instret, state_dbg
  );
endinterface

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU decoder: maps ALUOp plus funct3/funct7_5/op[5] to the 3-bit ALUControl.
module alu_decoder
  import multicycle_control_fsm_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7_5 only selects sub for R-type; for addi it is an immediate bit
          3'b000:  alu_control = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the RV32I multicycle core: sequences the shared
// datapath, decodes mux selects/enables and counts retired instructions.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned CNT_W         = 32,
  parameter bit          MEM_HANDSHAKE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_control_fsm_if.master bus
);

  state_t           state, state_nx;
  aluop_t           aluop;
  logic [CNT_W-1:0] instret;
  logic             ready, retire;
  logic             pcw, irw, mw, rw, illegal;
  logic             adr;
  logic [1:0]       res, srca, srcb;

  assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end

  always_comb begin
    state_nx = state;
    pcw      = 1'b0;
    irw      = 1'b0;
    mw       = 1'b0;
    rw       = 1'b0;
    adr      = 1'b0;
    illegal  = 1'b0;
    retire   = 1'b0;
    res      = RES_ALUOUT;
    srca     = SRCA_PC;
    srcb     = SRCB_RS2;
    aluop    = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        srcb = SRCB_FOUR;
        res  = RES_ALURESULT;
        pcw  = ready;
        irw  = ready;
        if (ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        srca = SRCA_OLDPC;
        srcb = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_R:         state_nx = S_EXECUTER;
          OP_I:         state_nx = S_EXECUTEI;
          OP_BEQ:       state_nx = S_BEQ;
          OP_JAL:       state_nx = S_JAL;
          default:      state_nx = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        srca     = SRCA_RS1;
        srcb     = SRCB_IMM;
        state_nx = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr = 1'b1;
        if (ready) state_nx = S_MEMWB;
      end
      S_MEMWB: begin
        res      = RES_DATA;
        rw       = 1'b1;
        retire   = 1'b1;
        state_nx = S_FETCH;
      end
      S_MEMWRITE: begin
        adr = 1'b1;
        mw  = 1'b1;
        if (ready) begin
          retire   = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_EXECUTER: begin
        srca     = SRCA_RS1;
        srcb     = SRCB_RS2;
        aluop    = ALUOP_FUNCT;
        state_nx = S_ALUWB;
      end
      S_EXECUTEI: begin
        srca     = SRCA_RS1;
        srcb     = SRCB_IMM;
        aluop    = ALUOP_FUNCT;
        state_nx = S_ALUWB;
      end
      S_ALUWB: begin
        rw       = 1'b1;
        retire   = 1'b1;
        state_nx = S_FETCH;
      end
      S_BEQ: begin
        srca     = SRCA_RS1;
        srcb     = SRCB_RS2;
        aluop    = ALUOP_SUB;
        pcw      = bus.zero;
        retire   = 1'b1;
        state_nx = S_FETCH;
      end
      S_JAL: begin
        srca     = SRCA_OLDPC;
        srcb     = SRCB_FOUR;
        pcw      = 1'b1;
        state_nx = S_ALUWB;
      end
      S_ILLEGAL: illegal = 1'b1;
      default:   state_nx = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .funct3      (bus.funct3),
    .funct7_5    (bus.funct7_5),
    .op5         (bus.op[5]),
    .alu_control (bus.ALUControl)
  );

  // Enables are gated by rst so FETCH's Mealy writes cannot fire while reset is held.
  assign bus.PCWrite       = rst & pcw;
  assign bus.IRWrite       = rst & irw;
  assign bus.MemWrite      = rst & mw;
  assign bus.RegWrite      = rst & rw;
  assign bus.AdrSrc        = adr;
  assign bus.ResultSrc     = res;
  assign bus.ALUSrcA       = srca;
  assign bus.ALUSrcB       = srcb;
  assign bus.ImmSrc        = imm_src(bus.op);
  assign bus.illegal_instr = illegal;
  assign bus.instret       = instret;
  assign bus.state_dbg     = state;

endmodule
